// File: rtl/grad_pack.sv
// grad_pack: 3x3 Sobel gradient with packed {magnitude, direction} output; optional GRAD_FLOOR_EN macro zeroes weak gradients below FLOOR
module grad_pack #(
    parameter int LINE_W = 640,
    parameter int FLOOR  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        pix_valid,
    input  logic [7:0]  pix_in,
    output logic        grad_valid,
    output logic [13:0] grad_out
);
    localparam int CW = $clog2(LINE_W);

    logic [CW-1:0] col, col_e;
    logic [1:0]    row, row_e;
    logic [7:0]    lb0 [LINE_W];
    logic [7:0]    lb1 [LINE_W];
    logic [7:0]    w [3][3];
    logic          v1, b1, v2, b2, s2, floor_hit;
    logic [10:0]   gx, gy;
    logic [9:0]    ax_c, ay_c, ax, ay;
    logic [11:0]   mag;
    logic [12:0]   ax2, ay2, ax5, ay5;
    logic [1:0]    dir;
    logic [13:0]   word;

    // sof re-addresses the current beat to (0,0); Sobel on the window, then classify the registered magnitudes
    always_comb begin
        col_e = sof ? '0 : col;
        row_e = sof ? '0 : row;
        gx = 11'(w[0][2]) + {2'b0, w[1][2], 1'b0} + 11'(w[2][2])
           - 11'(w[0][0]) - {2'b0, w[1][0], 1'b0} - 11'(w[2][0]);
        gy = 11'(w[2][0]) + {2'b0, w[2][1], 1'b0} + 11'(w[2][2])
           - 11'(w[0][0]) - {2'b0, w[0][1], 1'b0} - 11'(w[0][2]);
        ax_c = gx[10] ? 10'(-gx) : gx[9:0];
        ay_c = gy[10] ? 10'(-gy) : gy[9:0];
        mag = 12'(ax) + 12'(ay);
        ax2 = {2'b0, ax, 1'b0};
        ay2 = {2'b0, ay, 1'b0};
        ax5 = 13'(ax) * 13'd5;
        ay5 = 13'(ay) * 13'd5;
        dir = (ay5 <= ax2) ? 2'b00 : (ay2 >= ax5) ? 2'b10 : s2 ? 2'b11 : 2'b01;
`ifdef GRAD_FLOOR_EN
        floor_hit = mag < 12'(FLOOR);
`else
        floor_hit = 1'b0 && (mag < 12'(FLOOR));
`endif
        word = (b2 || floor_hit) ? 14'b0 : {mag, dir};
    end

    // raster position: col wraps per line, row saturates at 2 (only "two or more lines seen" matters)
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            col <= (col_e == CW'(LINE_W - 1)) ? '0 : col_e + 1'b1;
            row <= (col_e == CW'(LINE_W - 1) && row_e != 2'd2) ? row_e + 2'd1 : row_e;
        end else if (sof) begin
            col <= '0;
            row <= '0;
        end
    end

    // line buffers are never cleared; border masking hides stale contents
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb0[col_e] <= lb1[col_e];
            lb1[col_e] <= pix_in;
        end
    end

    // stage 1: shift the newest column into the window on each beat
    always_ff @(posedge clk) begin
        if (rst) begin
            w  <= '{default: '0};
            v1 <= 1'b0;
            b1 <= 1'b0;
        end else begin
            v1 <= pix_valid;
            b1 <= row_e < 2'd2 || col_e < CW'(2);
            if (pix_valid) begin
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= lb0[col_e];
                w[1][2] <= lb1[col_e];
                w[2][2] <= pix_in;
            end
        end
    end

    // stage 2: register absolute gradients and their sign relation
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            b2 <= 1'b0;
            ax <= '0;
            ay <= '0;
            s2 <= 1'b0;
        end else begin
            v2 <= v1;
            b2 <= b1;
            ax <= ax_c;
            ay <= ay_c;
            s2 <= gx[10] == gy[10];
        end
    end

    // stage 3: output word, held between valid beats
    always_ff @(posedge clk) begin
        if (rst) begin
            grad_valid <= 1'b0;
            grad_out   <= '0;
        end else begin
            grad_valid <= v2;
            if (v2) grad_out <= word;
        end
    end
endmodule

// File: tb/tb_grad_pack.sv
// tb_grad_pack: directed frames on an 8-pixel-wide grad_pack with hand-computed Sobel results
module tb_grad_pack;
    logic        clk = 1'b0;
    logic        rst, sof, pix_valid;
    logic [7:0]  pix_in;
    logic        grad_valid;
    logic [13:0] grad_out;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_q = 1'b1;
    logic mon_on = 1'b0;
    logic [13:0] last = '0;
    logic [13:0] oq[$];
    int oc[$];
    int ic[$];

    typedef struct {
        int pat;
        int cr;
        int cc;
        logic [13:0] exp;
    } vec_t;

`ifdef GRAD_FLOOR_EN
    localparam logic [13:0] EXP5 = 14'h000;
`else
    localparam logic [13:0] EXP5 = 14'h030;
`endif

    vec_t tbl [24];

    grad_pack #(.LINE_W(8), .FLOOR(16)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .grad_valid(grad_valid), .grad_out(grad_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // collect outputs and check that grad_out holds between valid beats
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_q) last = '0;
            else if (grad_valid) begin
                oq.push_back(grad_out);
                oc.push_back(cyc);
                last = grad_out;
            end else chk("hold", int'(grad_out), int'(last));
        end
    end

    function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
        case (pat)
            0: return 8'd100;
            1: return (c < 4) ? 8'd0 : 8'd200;
            2: return (r < 3) ? 8'd0 : 8'd200;
            3: return 8'(10 * (r + c));
            4: return 8'(10 * (r + 7 - c));
            default: return (c < 4) ? 8'd0 : 8'd3;
        endcase
    endfunction

    task automatic beat(input logic s, input logic [7:0] p);
        @(posedge clk);
        #1;
        sof = s;
        pix_valid = 1'b1;
        pix_in = p;
        ic.push_back(cyc);
    endtask

    task automatic idle(input logic s);
        @(posedge clk);
        #1;
        sof = s;
        pix_valid = 1'b0;
    endtask

    task automatic check_frame(input int pat);
        chk($sformatf("p%0d count", pat), oq.size(), 64);
        if (oq.size() == 64 && ic.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("p%0d latency %0d", pat, i), oc[i] - ic[i], 3);
                if (i / 8 < 2 || i % 8 < 2 || pat == 0)
                    chk($sformatf("p%0d zero r%0d c%0d", pat, i / 8, i % 8), int'(oq[i]), 0);
            end
            for (int t = 0; t < 24; t++)
                if (tbl[t].pat == pat)
                    chk($sformatf("p%0d centre r%0d c%0d", pat, tbl[t].cr, tbl[t].cc),
                        int'(oq[(tbl[t].cr + 1) * 8 + tbl[t].cc + 1]), int'(tbl[t].exp));
        end
        oq.delete();
        oc.delete();
        ic.delete();
    endtask

    task automatic run_frame(input int pat, input bit gaps, input bit sep_sof);
        if (sep_sof) idle(1'b1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) idle(1'b0);
                beat(!sep_sof && r == 0 && c == 0, pix_of(pat, r, c));
            end
        repeat (6) idle(1'b0);
        check_frame(pat);
    endtask

    initial begin
        tbl = '{
            '{0, 1, 1, 14'h000}, '{0, 3, 3, 14'h000}, '{0, 6, 6, 14'h000},
            '{1, 1, 3, 14'hC80}, '{1, 1, 4, 14'hC80}, '{1, 5, 3, 14'hC80}, '{1, 6, 4, 14'hC80},
            '{1, 2, 2, 14'h000}, '{1, 3, 5, 14'h000}, '{1, 6, 6, 14'h000},
            '{2, 2, 1, 14'hC82}, '{2, 2, 6, 14'hC82}, '{2, 3, 3, 14'hC82},
            '{2, 1, 3, 14'h000}, '{2, 4, 3, 14'h000},
            '{3, 1, 1, 14'h283}, '{3, 3, 4, 14'h283}, '{3, 6, 6, 14'h283},
            '{4, 1, 1, 14'h281}, '{4, 4, 2, 14'h281}, '{4, 6, 6, 14'h281},
            '{5, 2, 3, EXP5}, '{5, 2, 4, EXP5}, '{5, 2, 2, 14'h000}
        };
        rst = 1'b1;
        sof = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        chk("reset grad_valid", int'(grad_valid), 0);
        chk("reset grad_out", int'(grad_out), 0);
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b1);
        run_frame(3, 1'b0, 1'b0);
        run_frame(4, 1'b1, 1'b0);
        run_frame(5, 1'b0, 1'b0);
        run_frame(1, 1'b1, 1'b0);
        // reset lands on row 3 col 5; beats (3,3) and (3,4) are still in flight and must vanish
        for (int i = 0; i < 29; i++) beat(i == 0, pix_of(1, i / 8, i % 8));
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_in = 8'd200;
        sof = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        sof = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst valid %0d", k), int'(grad_valid), 0);
            chk($sformatf("post-rst out %0d", k), int'(grad_out), 0);
        end
        chk("pre-rst count", oq.size(), 27);
        oq.delete();
        oc.delete();
        ic.delete();
        run_frame(1, 1'b1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
